// File: rtl/parking_pkg.sv
// Shared types, defaults and helpers for the parking gate monitor.
package parking_pkg;

   localparam int DEF_CAPACITY    = 25;
   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_IN_A   = 3'd1,
      ST_IN_AB  = 3'd2,
      ST_IN_B   = 3'd3,
      ST_OUT_B  = 3'd4,
      ST_OUT_AB = 3'd5,
      ST_OUT_A  = 3'd6,
      ST_LOST   = 3'd7
   } lane_state_t;

   // Lane counts never exceed 8, so callers zero-extend their event vectors to 8 bits.
   function automatic logic [3:0] popcount(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
      return c;
   endfunction

endpackage

// File: rtl/parking_lane_fsm.sv
// One gate lane: sensor synchronisers, edge decode, direction FSM and registered ENTER/EXIT pulses.
module parking_lane_fsm
   import parking_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_a,
   input  logic sig_b,
   output logic enter_ev,
   output logic exit_ev,
   output logic enter_pulse,
   output logic exit_pulse
);

   localparam logic [3:0] E_RA = 4'b1000;
   localparam logic [3:0] E_FA = 4'b0100;
   localparam logic [3:0] E_RB = 4'b0010;
   localparam logic [3:0] E_FB = 4'b0001;

   logic [SYNC_STAGES-1:0] sync_a, sync_b;
   logic hist_a, hist_b;
   logic lvl_a, lvl_b;
   logic [3:0] edges;
   lane_state_t state, state_next;
   logic entry, leave;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
         hist_a <= 1'b0;
         hist_b <= 1'b0;
      end else begin
         sync_a <= {sync_a[SYNC_STAGES-2:0], sig_a};
         sync_b <= {sync_b[SYNC_STAGES-2:0], sig_b};
         hist_a <= sync_a[SYNC_STAGES-1];
         hist_b <= sync_b[SYNC_STAGES-1];
      end
   end

   assign lvl_a = sync_a[SYNC_STAGES-1];
   assign lvl_b = sync_b[SYNC_STAGES-1];
   assign edges = {lvl_a & ~hist_a, ~lvl_a & hist_a, lvl_b & ~hist_b, ~lvl_b & hist_b};

   // Exactly one expected edge advances the FSM; any other non-empty edge set drops to LOST.
   always_comb begin
      state_next = state;
      entry      = 1'b0;
      leave      = 1'b0;
      if (state == ST_LOST) begin
         if (!lvl_a && !lvl_b) state_next = ST_IDLE;
      end else if (edges != 4'b0000) begin
         state_next = ST_LOST;
         case (state)
            ST_IDLE: begin
               if (edges == E_RA)      state_next = ST_IN_A;
               else if (edges == E_RB) state_next = ST_OUT_B;
            end
            ST_IN_A: begin
               if (edges == E_RB)      state_next = ST_IN_AB;
               else if (edges == E_FA) state_next = ST_IDLE;
            end
            ST_IN_AB: begin
               if (edges == E_FA)      state_next = ST_IN_B;
               else if (edges == E_FB) state_next = ST_IN_A;
            end
            ST_IN_B: begin
               if (edges == E_FB) begin
                  state_next = ST_IDLE;
                  entry      = 1'b1;
               end else if (edges == E_RA) state_next = ST_IN_AB;
            end
            ST_OUT_B: begin
               if (edges == E_RA)      state_next = ST_OUT_AB;
               else if (edges == E_FB) state_next = ST_IDLE;
            end
            ST_OUT_AB: begin
               if (edges == E_FB)      state_next = ST_OUT_A;
               else if (edges == E_FA) state_next = ST_OUT_B;
            end
            ST_OUT_A: begin
               if (edges == E_FA) begin
                  state_next = ST_IDLE;
                  leave      = 1'b1;
               end else if (edges == E_RB) state_next = ST_OUT_AB;
            end
            default: ;
         endcase
      end
   end

   // The event is staged once before the pulse so the occupancy counter can update on the pulse edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         enter_ev    <= 1'b0;
         exit_ev     <= 1'b0;
         enter_pulse <= 1'b0;
         exit_pulse  <= 1'b0;
      end else begin
         state       <= state_next;
         enter_ev    <= entry;
         exit_ev     <= leave;
         enter_pulse <= enter_ev;
         exit_pulse  <= exit_ev;
      end
   end

endmodule

// File: rtl/parking_gate_monitor.sv
// Multi-lane gate monitor with a shared saturating occupancy counter.
// Optional lifetime entry/exit totals are enabled by defining PARKING_STATS_EN.
module parking_gate_monitor
   import parking_pkg::*;
#(
   parameter int NUM_LANES   = 2,
   parameter int CAPACITY    = DEF_CAPACITY,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   localparam int CNT_W      = $clog2(CAPACITY + 1)
) (
   input  logic                 CLOCK_50,
   input  logic                 RSTN,
   input  logic [NUM_LANES-1:0] SIG_A,
   input  logic [NUM_LANES-1:0] SIG_B,
   output logic [NUM_LANES-1:0] ENTER,
   output logic [NUM_LANES-1:0] EXIT,
   output logic [CNT_W-1:0]     OCCUPANCY,
   output logic                 FULL,
   output logic                 EMPTY,
   output logic                 ALARM
`ifdef PARKING_STATS_EN
   ,
   output logic [15:0]          TOTAL_IN,
   output logic [15:0]          TOTAL_OUT
`endif
);

   localparam logic signed [CNT_W+3:0] CAP_S = signed'((CNT_W + 4)'(CAPACITY));

   logic [NUM_LANES-1:0] ent_ev, ext_ev;
   logic [7:0] ent_pad, ext_pad;
   logic [3:0] n_in, n_out;
   logic signed [CNT_W+3:0] sum;
   logic [CNT_W-1:0] occ_next;
   logic clamp;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      parking_lane_fsm #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_lane (
         .clk         (CLOCK_50),
         .rst_n       (RSTN),
         .sig_a       (SIG_A[i]),
         .sig_b       (SIG_B[i]),
         .enter_ev    (ent_ev[i]),
         .exit_ev     (ext_ev[i]),
         .enter_pulse (ENTER[i]),
         .exit_pulse  (EXIT[i])
      );
   end

   // All lanes completing in one cycle are netted together, then clamped to [0, CAPACITY].
   always_comb begin
      ent_pad = '0;
      ext_pad = '0;
      ent_pad[NUM_LANES-1:0] = ent_ev;
      ext_pad[NUM_LANES-1:0] = ext_ev;
      n_in  = popcount(ent_pad);
      n_out = popcount(ext_pad);
      sum   = signed'({4'b0000, OCCUPANCY}) + signed'((CNT_W + 4)'(n_in))
              - signed'((CNT_W + 4)'(n_out));
      clamp    = 1'b0;
      occ_next = sum[CNT_W-1:0];
      if (sum < 0) begin
         clamp    = 1'b1;
         occ_next = '0;
      end else if (sum > CAP_S) begin
         clamp    = 1'b1;
         occ_next = CNT_W'(CAPACITY);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RSTN) begin
      if (!RSTN) begin
         OCCUPANCY <= '0;
         ALARM     <= 1'b0;
      end else begin
         OCCUPANCY <= occ_next;
         ALARM     <= clamp;
      end
   end

   assign FULL  = (OCCUPANCY == CNT_W'(CAPACITY));
   assign EMPTY = (OCCUPANCY == '0);

`ifdef PARKING_STATS_EN
   always_ff @(posedge CLOCK_50 or negedge RSTN) begin
      if (!RSTN) begin
         TOTAL_IN  <= '0;
         TOTAL_OUT <= '0;
      end else begin
         TOTAL_IN  <= TOTAL_IN + 16'(n_in);
         TOTAL_OUT <= TOTAL_OUT + 16'(n_out);
      end
   end
`endif

endmodule

// File: tb/tb_parking_gate_monitor.sv
// Scoreboard bench for parking_gate_monitor: passages push expected pulses, a monitor pops and compares.
module tb_parking_gate_monitor;

   localparam int L   = 2;
   localparam int CAP = 25;
   localparam int S   = 2;
   localparam int CW  = $clog2(CAP + 1);

   typedef struct {
      int         cyc;
      logic [1:0] en;
      logic [1:0] ex;
      int         occ;
      logic       alarm;
   } exp_t;

   logic clk = 1'b0;
   logic rstn;
   logic [L-1:0] sig_a, sig_b, enter, exit_o;
   logic [CW-1:0] occ;
   logic full, empty, alarm;
`ifdef PARKING_STATS_EN
   logic [15:0] total_in, total_out;
`endif

   exp_t exp_q[$];
   exp_t mon_e;
   int cyc = 0, checks = 0, errors = 0;
   int model_occ = 0, cur_occ = 0, tot_in = 0, tot_out = 0;

   parking_gate_monitor #(
      .NUM_LANES   (L),
      .CAPACITY    (CAP),
      .SYNC_STAGES (S)
   ) dut (
      .CLOCK_50  (clk),
      .RSTN      (rstn),
      .SIG_A     (sig_a),
      .SIG_B     (sig_b),
      .ENTER     (enter),
      .EXIT      (exit_o),
      .OCCUPANCY (occ),
      .FULL      (full),
      .EMPTY     (empty),
      .ALARM     (alarm)
`ifdef PARKING_STATS_EN
      ,
      .TOTAL_IN  (total_in),
      .TOTAL_OUT (total_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Called at a negedge; holds the sensor levels for the given number of cycles.
   task automatic applyStimulus(input logic [L-1:0] a, input logic [L-1:0] b, input int hold);
      sig_a = a;
      sig_b = b;
      repeat (hold) @(negedge clk);
   endtask

   // Entry lanes walk A, AB, B, none; exit lanes walk B, AB, A, none; both complete on the last step.
   task automatic runPassage(input logic [L-1:0] en, input logic [L-1:0] ex);
      int raw;
      logic alm;
      applyStimulus(en, ex, 6);
      applyStimulus(en | ex, en | ex, 6);
      applyStimulus(ex, en, 6);
      raw = model_occ + $countones(en) - $countones(ex);
      alm = 1'b0;
      if (raw < 0) begin
         raw = 0;
         alm = 1'b1;
      end else if (raw > CAP) begin
         raw = CAP;
         alm = 1'b1;
      end
      model_occ = raw;
      tot_in  += $countones(en);
      tot_out += $countones(ex);
      exp_q.push_back('{cyc + S + 2, en, ex, raw, alm});
      applyStimulus('0, '0, 8);
   endtask

   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (!rstn) begin
         exp_q.delete();
         cur_occ = 0;
      end else begin
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            cur_occ = mon_e.occ;
            checkOutput("enter", int'(enter), int'(mon_e.en));
            checkOutput("exit", int'(exit_o), int'(mon_e.ex));
            checkOutput("alarm", int'(alarm), int'(mon_e.alarm));
         end else begin
            checkOutput("enter_idle", int'(enter), 0);
            checkOutput("exit_idle", int'(exit_o), 0);
            checkOutput("alarm_idle", int'(alarm), 0);
         end
         checkOutput("occupancy", int'(occ), cur_occ);
         checkOutput("full", int'(full), int'(cur_occ == CAP));
         checkOutput("empty", int'(empty), int'(cur_occ == 0));
      end
   end

   initial begin
      rstn  = 1'b0;
      sig_a = '0;
      sig_b = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_enter", int'(enter), 0);
      checkOutput("rst_exit", int'(exit_o), 0);
      checkOutput("rst_occ", int'(occ), 0);
      checkOutput("rst_full", int'(full), 0);
      checkOutput("rst_empty", int'(empty), 1);
      checkOutput("rst_alarm", int'(alarm), 0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      runPassage(2'b01, 2'b00);
      runPassage(2'b00, 2'b10);
      runPassage(2'b00, 2'b01);

      // Reversal on lane 0: backs out without an event.
      applyStimulus(2'b01, 2'b00, 6);
      applyStimulus(2'b01, 2'b01, 6);
      applyStimulus(2'b01, 2'b00, 6);
      applyStimulus(2'b00, 2'b00, 8);

      // Simultaneous rise on lane 1 goes LOST, then recovers.
      applyStimulus(2'b10, 2'b10, 6);
      applyStimulus(2'b00, 2'b00, 8);
      runPassage(2'b10, 2'b00);

      for (int i = 0; i < 23; i++) runPassage((i % 2 == 0) ? 2'b01 : 2'b10, 2'b00);
      runPassage(2'b11, 2'b00);
      runPassage(2'b01, 2'b00);
      runPassage(2'b01, 2'b10);
      runPassage(2'b00, 2'b10);

      // Reset while lane 0 is mid-passage.
      applyStimulus(2'b01, 2'b00, 6);
      applyStimulus(2'b01, 2'b01, 6);
      rstn = 1'b0;
      #1;
      checkOutput("midrst_enter", int'(enter), 0);
      checkOutput("midrst_exit", int'(exit_o), 0);
      checkOutput("midrst_occ", int'(occ), 0);
      checkOutput("midrst_full", int'(full), 0);
      checkOutput("midrst_empty", int'(empty), 1);
      checkOutput("midrst_alarm", int'(alarm), 0);
      sig_a = '0;
      sig_b = '0;
      model_occ = 0;
      tot_in  = 0;
      tot_out = 0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      applyStimulus(2'b00, 2'b00, 10);
      runPassage(2'b01, 2'b00);

      for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
      checkOutput("drain", exp_q.size(), 0);
`ifdef PARKING_STATS_EN
      checkOutput("total_in", int'(total_in), tot_in % 65536);
      checkOutput("total_out", int'(total_out), tot_out % 65536);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
